// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: issues word fetches over a req/ack handshake
// and buffers returned instructions with their PCs in an in-order FIFO for decode.
module ifetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                AW       = 32,
    parameter logic [AW-1:0]     RESET_PC = '0
) (
    input  logic                     CLK,
    input  logic                     RST,
    output logic                     mem_req,
    output logic [AW-1:0]            mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    input  logic                     StallF,
    input  logic                     Redirect,
    input  logic [AW-1:0]            RedirectPC,
    output logic [31:0]              InstrF,
    output logic [AW-1:0]            PCF,
    output logic                     InstrValid,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   fpc, fpc_nxt;
    logic [AW-1:0]   addr_nxt;
    logic            req_nxt;

    logic [31:0]     instr_mem [DEPTH];
    logic [AW-1:0]   pc_mem    [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;

    logic            push;
    logic            pop;
    logic [AW-1:0]   target;
    logic [CW-1:0]   occ_after;

    assign target     = RedirectPC & ~AW'(3);
    assign InstrValid = (count != '0);
    assign pop        = InstrValid & ~StallF & ~Redirect;
    // Occupancy after this cycle's pop plus the push being accepted now.
    assign occ_after  = count + CW'(1) - CW'(pop);

    assign InstrF = InstrValid ? instr_mem[rd_ptr] : '0;
    assign PCF    = InstrValid ? pc_mem[rd_ptr]    : '0;
    assign Count  = count;

    always_comb begin
        state_nxt = state;
        fpc_nxt   = fpc;
        req_nxt   = mem_req;
        addr_nxt  = mem_addr;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (Redirect) begin
                    fpc_nxt = target;
                end else if (count < CW'(DEPTH)) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    addr_nxt  = fpc;
                end
            end
            REQ: begin
                if (Redirect) begin
                    fpc_nxt = target;
                    if (mem_ack) begin
                        state_nxt = IDLE;
                        req_nxt   = 1'b0;
                    end else begin
                        state_nxt = DISCARD;
                    end
                end else if (mem_ack) begin
                    push    = 1'b1;
                    fpc_nxt = mem_addr + AW'(4);
                    if (occ_after < CW'(DEPTH)) begin
                        addr_nxt = mem_addr + AW'(4);
                    end else begin
                        state_nxt = IDLE;
                        req_nxt   = 1'b0;
                    end
                end
            end
            DISCARD: begin
                // Request stays on the bus until acked; its data is dropped.
                if (Redirect) begin
                    fpc_nxt = target;
                end
                if (mem_ack) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            fpc      <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fpc      <= fpc_nxt;
            mem_req  <= req_nxt;
            mem_addr <= addr_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (Redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST && push) begin
            instr_mem[wr_ptr] <= mem_rdata;
            pc_mem[wr_ptr]    <= mem_addr;
        end
    end

endmodule
